// File: rtl/dpmem_port_pkg.sv
// Shared encodings for the dpmem port master: command opcodes and controller states.
package dpmem_port_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

endpackage

// File: rtl/dpmem_port_master_if.sv
// Command/response channel bundle between a sequencer (master) and the port master (slave).
interface dpmem_port_master_if
  import dpmem_port_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 4
) ();

  logic          req_valid;
  logic          req_ready;
  op_e           req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          busy;

  modport master (
    output req_valid, req_op, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, busy
  );

endinterface

// File: rtl/dpmem.sv
// 2**AW x DW dual-port memory: synchronous write on wc, registered read on rc, no reset.
module dpmem #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          rc,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd,
  input  logic          wc,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge wc) begin
    if (we) mem_q[wa] <= wd;
  end

  always_ff @(posedge rc) begin
    rd <= mem_q[ra];
  end

endmodule

// File: rtl/dpmem_rsp_fifo.sv
// Small synchronous FIFO holding read responses; output word stays put until popped.
module dpmem_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic                         valid,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok, full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign valid = (count_q != '0);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign pop_ok  = pop && valid;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dpmem_port_master.sv
// Command initiator for a dpmem instance: reads, writes and whole-memory fills,
// with in-order read responses buffered in a small FIFO.
module dpmem_port_master
  import dpmem_port_pkg::*;
#(
  parameter int AW        = 4,
  parameter int DW        = 4,
  parameter int RSP_DEPTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  dpmem_port_master_if.slave  bus,
  output logic [AW-1:0]       ra,
  input  logic [DW-1:0]       rd,
  output logic                we,
  output logic [AW-1:0]       wa,
  output logic [DW-1:0]       wd
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  state_e        state_q, state_d;
  logic [AW-1:0] fill_cnt_q, fill_cnt_d;
  logic [DW-1:0] fill_data_q, fill_data_d;
  logic [AW-1:0] cap_addr_q, cap_addr_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          room;
  logic [AW+DW-1:0] rsp_word;

  // Credit check uses only registered state, so rsp_ready never reaches req_ready.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign room      = (occupancy < (CW+1)'(RSP_DEPTH));
  assign ra        = bus.req_addr;

  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    fill_data_d   = fill_data_q;
    cap_addr_d    = cap_addr_q;
    inflight_d    = 1'b0;
    bus.req_ready = 1'b0;
    bus.busy      = 1'b0;
    we            = 1'b0;
    wa            = bus.req_addr;
    wd            = bus.req_data;
    case (state_q)
      IDLE: begin
        bus.req_ready = room;
        if (bus.req_valid && room) begin
          case (bus.req_op)
            OP_READ: begin
              inflight_d = 1'b1;
              cap_addr_d = bus.req_addr;
            end
            OP_WRITE: we = 1'b1;
            OP_FILL: begin
              fill_data_d = bus.req_data;
              fill_cnt_d  = '0;
              state_d     = FILL;
            end
            default: ;
          endcase
        end
      end
      FILL: begin
        bus.busy   = 1'b1;
        we         = 1'b1;
        wa         = fill_cnt_q;
        wd         = fill_data_q;
        fill_cnt_d = fill_cnt_q + AW'(1);
        if (&fill_cnt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_cnt_q  <= '0;
      fill_data_q <= '0;
      cap_addr_q  <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_data_q <= fill_data_d;
      cap_addr_q  <= cap_addr_d;
      inflight_q  <= inflight_d;
    end
  end

  // rd is valid the cycle after acceptance, which is exactly when inflight_q is set.
  dpmem_rsp_fifo #(
    .W     (AW + DW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   ({cap_addr_q, rd}),
    .pop   (bus.rsp_ready),
    .valid (bus.rsp_valid),
    .dout  (rsp_word),
    .count (fifo_count)
  );

  assign {bus.rsp_addr, bus.rsp_data} = rsp_word;

endmodule
